uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_rx_core.sv | 157 +++++++++++++++
 tb/tb_uart_rx_core.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive/transmit blocks.
//   rx_state_t     : receiver FSM states
//   UART_DATA_BITS : data bits per frame
//   UART_MIN_DIV   : smallest usable clocks-per-bit divider
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 2;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable down-counter that flags the cycle its count reaches zero.
//   clk_i, rst_n_i : clock, async active-low reset
//   i_load         : load i_load_val and start counting
//   i_load_val     : cycles minus one until o_expire
//   o_expire       : one-cycle pulse when the loaded count has run down to zero
module uart_bit_timer #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               i_load,
    input  logic [D_WIDTH-1:0] i_load_val,
    output logic               o_expire
);
    logic [D_WIDTH-1:0] r_cnt;
    logic               r_run;

    // Expiry is gated by r_run so an idle timer parked at zero stays quiet.
    assign o_expire = r_run && (r_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
            r_run <= 1'b1;
        end else if (o_expire) begin
            r_run <= 1'b0;
        end else if (r_run) begin
            r_cnt <= r_cnt - D_WIDTH'(1);
        end
    end
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 serial receive deserializer with valid/ready byte output.
//   clk_i, rst_n_i : clock, async active-low reset
//   baud_div_i     : clocks per bit, latched at start-edge detection (min 2)
//   rx_i           : asynchronous serial line, idle high, LSB first
//   out_data_o     : received byte, out_valid_o/out_ready_i handshake
//   frame_err_o    : one-cycle pulse, stop bit sampled low (byte dropped)
//   overrun_o      : one-cycle pulse, byte completed while holding register full
//   UART_RX_PARITY_EN adds parity_odd_i and parity_err_o (one parity bit before stop)
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [D_WIDTH-1:0] baud_div_i,
    input  logic               rx_i,
    output logic [7:0]         out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
`ifdef UART_RX_PARITY_EN
    input  logic               parity_odd_i,
    output logic               parity_err_o,
`endif
    output logic               frame_err_o,
    output logic               overrun_o
);
    rx_state_t                   r_state, w_next;
    logic                        r_rx_s1, r_rx_s, r_rx_q;
    logic                        r_live, r_armed;
    logic [D_WIDTH-1:0]          r_div, w_div_in, w_load_val;
    logic [UART_DATA_BITS-1:0]   r_shreg;
    logic [2:0]                  r_bit;
    logic                        w_load, w_expire, w_start;
`ifdef UART_RX_PARITY_EN
    logic                        r_par;
`endif

    assign w_div_in = (baud_div_i < D_WIDTH'(UART_MIN_DIV)) ? D_WIDTH'(UART_MIN_DIV) : baud_div_i;
    // r_armed only sets once the line has been seen high after reset, so a line
    // already low when reset releases is not mistaken for a start edge.
    assign w_start  = r_armed && r_rx_q && !r_rx_s;

    uart_bit_timer #(.D_WIDTH(D_WIDTH)) u_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = r_div - D_WIDTH'(1);
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next     = START;
                    w_load     = 1'b1;
                    w_load_val = (w_div_in >> 1) - D_WIDTH'(1);
                end
            end
            START: begin
                if (w_expire) begin
                    w_next = r_rx_s ? IDLE : DATA;
                    w_load = !r_rx_s;
                end
            end
            DATA: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_bit == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    w_next = STOP;
                end
            end
`endif
            STOP: begin
                if (w_expire) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rx_s1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_q      <= 1'b1;
            r_live      <= 1'b0;
            r_armed     <= 1'b0;
            r_div       <= '0;
            r_shreg     <= '0;
            r_bit       <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            parity_err_o <= 1'b0;
`endif
        end else begin
            r_rx_s1     <= rx_i;
            r_rx_s      <= r_rx_s1;
            r_rx_q      <= r_rx_s;
            r_live      <= 1'b1;
            r_armed     <= r_armed | (r_live & r_rx_s1);
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
            if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
            if (r_state == IDLE && w_start) r_div <= w_div_in;
            if (r_state == START && w_expire) r_bit <= '0;
            if (r_state == DATA && w_expire) begin
                r_shreg <= {r_rx_s, r_shreg[UART_DATA_BITS-1:1]};
                r_bit   <= r_bit + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == PARITY && w_expire) r_par <= r_rx_s;
`endif
            if (r_state == STOP && w_expire) begin
                if (!r_rx_s) begin
                    frame_err_o <= 1'b1;
                end else if (!out_valid_o || out_ready_i) begin
                    // An accept in this same cycle frees the register for the new byte.
                    out_data_o  <= r_shreg;
                    out_valid_o <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    parity_err_o <= ((^r_shreg) ^ r_par) != parity_odd_i;
`endif
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: frame-level model and directed frames checking uart_rx_core.
module tb_uart_rx_core;
    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [31:0] baud_div_i;
    logic        rx_i;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        frame_err_o;
    logic        overrun_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected outcome of each frame, keyed by the cycle its result becomes visible.
    int         ev_kind[int];
    logic [7:0] ev_byte[int];

    logic       m_v = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
    logic [7:0] m_d = 8'h00;
    logic       prev_v = 1'b0;
    int rise_cnt = 0, rise_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, xfer_cnt = 0;
    logic [7:0] rise_data = 8'h00;

    uart_rx_core #(.D_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .baud_div_i  (baud_div_i),
        .rx_i        (rx_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step(1);
    endtask

    // Drives one frame (start, 8 data LSB first, stop) and records its expected result.
    // rx_i is left at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pulse,
                              input logic chg_div, output int n0);
        int dd, h, tp;
        logic [9:0] bits;
        logic [31:0] saved;
        step(1);
        n0    = cyc;
        saved = baud_div_i;
        dd    = (baud_div_i < 32'd2) ? 2 : int'(baud_div_i);
        h     = dd / 2;
        bits  = {stop, b, 1'b0};
        ev_kind[n0 + 3 + h + 9 * dd] = stop ? 1 : 2;
        ev_byte[n0 + 3 + h + 9 * dd] = b;
        if (pulse) begin
            tp = n0 + 2 + h + 9 * dd;
            fork
                begin
                    wait_cyc(tp);
                    out_ready_i = 1'b1;
                    step(1);
                    out_ready_i = 1'b0;
                end
            join_none
        end
        for (int k = 0; k < 10; k++) begin
            rx_i = bits[k];
            if (chg_div && k == 1) baud_div_i = 32'd7;
            step(dd);
        end
        baud_div_i = saved;
    endtask

    always @(negedge clk) begin
        logic old_v;
        if (!rst_n_i) begin
            m_v = 1'b0; m_d = 8'h00; m_fe = 1'b0; m_ov = 1'b0;
        end
        chk("valid", 32'(out_valid_o), 32'(m_v));
        chk("data", 32'(out_data_o), 32'(m_d));
        chk("frame_err", 32'(frame_err_o), 32'(m_fe));
        chk("overrun", 32'(overrun_o), 32'(m_ov));
        if (out_valid_o && !prev_v) begin
            rise_cnt++;
            rise_cyc  = cyc;
            rise_data = out_data_o;
        end
        prev_v = out_valid_o;
        ferr_cnt += int'(frame_err_o);
        ovr_cnt  += int'(overrun_o);
        if (rst_n_i && out_valid_o && out_ready_i) xfer_cnt++;
        if (rst_n_i) begin
            old_v = m_v;
            m_fe  = 1'b0;
            m_ov  = 1'b0;
            if (old_v && out_ready_i) m_v = 1'b0;
            if (ev_kind.exists(cyc + 1)) begin
                if (ev_kind[cyc + 1] == 2) m_fe = 1'b1;
                else if (!old_v || out_ready_i) begin
                    m_v = 1'b1;
                    m_d = ev_byte[cyc + 1];
                end else m_ov = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, r0, f0, o0, x0;
        rst_n_i = 1'b0; rx_i = 1'b1; baud_div_i = 32'd16; out_ready_i = 1'b1;
        step(3);
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", 32'(out_data_o), 32'd0);
        chk("rst_ferr", 32'(frame_err_o), 32'd0);
        chk("rst_ovr", 32'(overrun_o), 32'd0);
        rst_n_i = 1'b1;
        step(20);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, n0);
        step(5);
        chk("a5_rise_cycle", 32'(rise_cyc), 32'(n0 + 155));
        chk("a5_data", 32'(rise_data), 32'h0000_00A5);
        chk("a5_no_errors", 32'(ferr_cnt + ovr_cnt), 32'd0);

        r0 = rise_cnt;
        rx_i = 1'b0; step(4); rx_i = 1'b1; step(40);
        chk("glitch_no_valid", 32'(rise_cnt), 32'(r0));
        chk("glitch_no_ferr", 32'(ferr_cnt), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, n0);
        step(5);
        chk("3c_data", 32'(rise_data), 32'h0000_003C);
        chk("3c_rise_cycle", 32'(rise_cyc), 32'(n0 + 155));

        r0 = rise_cnt; f0 = ferr_cnt;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, n0);
        step(100);
        chk("7e_ferr_once", 32'(ferr_cnt), 32'(f0 + 1));
        chk("7e_no_valid", 32'(rise_cnt), 32'(r0));
        rx_i = 1'b1; step(30);
        chk("break_no_retrigger", 32'(ferr_cnt + rise_cnt), 32'(f0 + 1 + r0));

        out_ready_i = 1'b0; o0 = ovr_cnt; x0 = xfer_cnt;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, n0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, n0);
        step(5);
        chk("ovr_data_held", 32'(out_data_o), 32'h0000_0011);
        chk("ovr_valid_held", 32'(out_valid_o), 32'd1);
        chk("ovr_pulse", 32'(ovr_cnt), 32'(o0 + 1));
        out_ready_i = 1'b1; step(1); out_ready_i = 1'b0;
        chk("ovr_valid_drop", 32'(out_valid_o), 32'd0);
        step(5);
        chk("ovr_one_xfer", 32'(xfer_cnt), 32'(x0 + 1));

        send_frame(8'h11, 1'b1, 1'b0, 1'b0, n0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0, n0);
        step(5);
        chk("coinc_data", 32'(out_data_o), 32'h0000_0022);
        chk("coinc_valid", 32'(out_valid_o), 32'd1);
        chk("coinc_no_ovr", 32'(ovr_cnt), 32'(o0 + 1));
        out_ready_i = 1'b1; step(3);

        rx_i = 1'b0; step(16); rx_i = 1'b1; step(40);
        rx_i = 1'b0; rst_n_i = 1'b0; step(1);
        chk("mid_rst_data", 32'(out_data_o), 32'd0);
        chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
        step(3);
        rst_n_i = 1'b1;
        r0 = rise_cnt; f0 = ferr_cnt;
        step(60);
        chk("low_after_rst_quiet", 32'(rise_cnt + ferr_cnt), 32'(r0 + f0));
        rx_i = 1'b1; baud_div_i = 32'd0; step(10);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, n0);
        step(5);
        chk("5a_data", 32'(rise_data), 32'h0000_005A);
        chk("5a_rise_cycle_div2", 32'(rise_cyc), 32'(n0 + 22));
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
